// File: rtl/temporal_encoder.sv
// temporal_encoder: folded N-gram binder. Keeps the newest NGRAM_SIZE input
// hypervectors. Each one is rotated by its age and all of them are XORed together.
// The result is written into the output register one FOLD_WIDTH slice per
// cycle. A finished result is then offered on a valid/ready port.
module temporal_encoder #(
  parameter int unsigned NGRAM_SIZE      = 3,
  parameter int unsigned NUM_FOLDS       = 5,
  parameter int unsigned NUM_FOLDS_WIDTH = 3,
  parameter int unsigned FOLD_WIDTH      = 400,
  parameter int unsigned HV_DIMENSION    = NUM_FOLDS * FOLD_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    seq_clear,
  input  logic                    hvin_valid,
  output logic                    hvin_ready,
  input  logic [HV_DIMENSION-1:0] hvin,
  output logic                    hvout_valid,
  input  logic                    hvout_ready,
  output logic [HV_DIMENSION-1:0] hvout
);

  // fill never exceeds NGRAM_SIZE-1 <= 3
  localparam int unsigned FILL_W = 2;
  localparam logic [FILL_W-1:0]          FILL_MAX  = FILL_W'(NGRAM_SIZE - 1);
  localparam logic [NUM_FOLDS_WIDTH-1:0] LAST_FOLD = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUT     = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [HV_DIMENSION-1:0]    hist_q [NGRAM_SIZE];
  logic [HV_DIMENSION-1:0]    hist_d [NGRAM_SIZE];
  logic [FILL_W-1:0]          fill_q, fill_d;
  logic [FILL_W-1:0]          fill_pre;
  logic [NUM_FOLDS_WIDTH-1:0] fold_q, fold_d;
  logic [HV_DIMENSION-1:0]    hvout_q, hvout_d;
  logic                       hvin_ready_q;
  logic                       hvout_valid_q;
  logic [HV_DIMENSION-1:0]    bound_c;

  // Circular rotation by k: bit j moves to bit (j+k) mod D
  function automatic logic [HV_DIMENSION-1:0] rotl(input logic [HV_DIMENSION-1:0] x,
                                                  input int unsigned k);
    return (x << k) | (x >> (HV_DIMENSION - k));
  endfunction

  // Full N-gram bind of the current history; COMPUTE samples one slice per cycle
  always_comb begin
    bound_c = '0;
    for (int k = 0; k < NGRAM_SIZE; k++) begin
      bound_c = bound_c ^ rotl(hist_q[k], k);
    end
  end

  // Next-state, history, fill and fold logic
  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    fill_pre = fill_q;
    fold_d   = fold_q;
    hvout_d  = hvout_q;

    case (state_q)
      IDLE: begin
        // A sequence boundary takes effect before any input accepted in the same cycle
        if (seq_clear) begin
          fill_pre = '0;
          fill_d   = '0;
        end
        if (hvin_valid) begin
          hist_d[0] = hvin;
          for (int k = 1; k < NGRAM_SIZE; k++) begin
            hist_d[k] = hist_q[k-1];
          end
          if (fill_pre < FILL_MAX) begin
            fill_d = fill_pre + FILL_W'(1);
          end else begin
            fill_d  = fill_pre;
            state_d = COMPUTE;
            fold_d  = '0;
          end
        end
      end
      COMPUTE: begin
        for (int f = 0; f < NUM_FOLDS; f++) begin
          if (fold_q == NUM_FOLDS_WIDTH'(f)) begin
            hvout_d[f*FOLD_WIDTH +: FOLD_WIDTH] = bound_c[f*FOLD_WIDTH +: FOLD_WIDTH];
          end
        end
        if (fold_q == LAST_FOLD) begin
          state_d = OUT;
          fold_d  = '0;
        end else begin
          fold_d = fold_q + NUM_FOLDS_WIDTH'(1);
        end
      end
      OUT: begin
        if (hvout_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; handshake flags are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      for (int k = 0; k < NGRAM_SIZE; k++) begin
        hist_q[k] <= '0;
      end
      fill_q        <= '0;
      fold_q        <= '0;
      hvout_q       <= '0;
      hvin_ready_q  <= 1'b1;
      hvout_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hist_q        <= hist_d;
      fill_q        <= fill_d;
      fold_q        <= fold_d;
      hvout_q       <= hvout_d;
      hvin_ready_q  <= (state_d == IDLE);
      hvout_valid_q <= (state_d == OUT);
    end
  end

  assign hvin_ready  = hvin_ready_q;
  assign hvout_valid = hvout_valid_q;
  assign hvout       = hvout_q;

endmodule

// File: tb/tb_temporal_encoder.sv
// Bench for temporal_encoder. Directed cases come from the design notes and are
// followed by random traffic. Results are checked against a queue-based N-gram model.
module tb_temporal_encoder;

  localparam int unsigned D  = 2000;
  localparam int unsigned N  = 3;
  localparam int unsigned NF = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         seq_clear;
  logic         hvin_valid;
  logic         hvin_ready;
  logic [D-1:0] hvin;
  logic         hvout_valid;
  logic         hvout_ready;
  logic [D-1:0] hvout;

  int errors = 0;
  int checks = 0;
  int exp_outs = 0;
  int obs_outs = 0;

  logic [D-1:0] mq[$];
  int           mfill = 0;
  logic [D-1:0] last_out;

  always #5 clk = ~clk;

  temporal_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .seq_clear  (seq_clear),
    .hvin_valid (hvin_valid),
    .hvin_ready (hvin_ready),
    .hvin       (hvin),
    .hvout_valid(hvout_valid),
    .hvout_ready(hvout_ready),
    .hvout      (hvout)
  );

  // Count output handshakes
  always @(posedge clk) begin
    if (!rst && hvout_valid && hvout_ready) obs_outs++;
  end

  task automatic check(input string tag, input logic [D-1:0] got, input logic [D-1:0] exp);
    int fd;
    checks++;
    if (got !== exp) begin
      errors++;
      fd = -1;
      for (int i = 0; i < D; i++) begin
        if (fd < 0 && got[i] !== exp[i]) fd = i;
      end
      $display("FAIL %s: got ones=%0d low64=%h, expected ones=%0d low64=%h, first differing bit %0d",
               tag, $countones(got), got[63:0], $countones(exp), exp[63:0], fd);
    end
  endtask

  function automatic logic [D-1:0] onehot(input int b);
    logic [D-1:0] r;
    r = '0;
    r[b] = 1'b1;
    return r;
  endfunction

  function automatic logic [D-1:0] rand_hv();
    logic [D-1:0] r;
    for (int i = 0; i < D; i++) r[i] = 1'($urandom);
    return r;
  endfunction

  // out[i] = XOR over ages k of hist[k][(i-k) mod D]
  function automatic logic [D-1:0] model_out();
    logic [D-1:0] r;
    int src;
    r = '0;
    for (int i = 0; i < D; i++) begin
      for (int k = 0; k < N; k++) begin
        src = i - k;
        if (src < 0) src += D;
        r[i] = r[i] ^ mq[k][src];
      end
    end
    return r;
  endfunction

  // Present one input. Optionally hold backpressure, pulse seq_clear during
  // COMPUTE, or reset on the 3rd COMPUTE cycle. Called at a negedge.
  task automatic send(input logic [D-1:0] hv, input bit clr, input int hold,
                      input bit clr_mid, input bit rst_mid);
    int n;
    bit expect_out;
    logic [D-1:0] e;
    hvin       = hv;
    hvin_valid = 1'b1;
    seq_clear  = clr;
    n = 0;
    while (!hvin_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!hvin_ready) begin
      check("hvin_ready_timeout", D'(hvin_ready), D'(1'b1));
      hvin_valid = 1'b0;
      seq_clear  = 1'b0;
      return;
    end
    if (clr) mfill = 0;
    expect_out = !(mfill < N - 1);
    mq.push_front(hv);
    if (mq.size() > N) void'(mq.pop_back());
    if (mfill < N - 1) mfill++;
    @(negedge clk);
    hvin_valid = 1'b0;
    seq_clear  = 1'b0;

    if (rst_mid) begin
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_ready", D'(hvin_ready), D'(1'b1));
      check("rst_mid_valid", D'(hvout_valid), D'(1'b0));
      check("rst_mid_hvout", hvout, '0);
      rst = 1'b0;
      mq.delete();
      mfill = 0;
      return;
    end

    if (!expect_out) begin
      check("warmup_valid", D'(hvout_valid), D'(1'b0));
      check("warmup_ready", D'(hvin_ready), D'(1'b1));
      return;
    end

    exp_outs++;
    e = model_out();
    n = 1;
    while (!hvout_valid && n < 50) begin
      seq_clear = (clr_mid && n == 1);
      @(negedge clk);
      n++;
    end
    seq_clear = 1'b0;
    check("latency", D'(n), D'(NF + 1));
    check("hvout_valid", D'(hvout_valid), D'(1'b1));
    check("ready_in_out", D'(hvin_ready), D'(1'b0));
    check("hvout", hvout, e);
    last_out = hvout;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("bp_valid", D'(hvout_valid), D'(1'b1));
      check("bp_ready", D'(hvin_ready), D'(1'b0));
      check("bp_stable", hvout, e);
    end
    hvout_ready = 1'b1;
    @(negedge clk);
    hvout_ready = 1'b0;
    check("post_fire_valid", D'(hvout_valid), D'(1'b0));
    check("post_fire_ready", D'(hvin_ready), D'(1'b1));
  endtask

  initial begin
    rst         = 1'b1;
    seq_clear   = 1'b0;
    hvin_valid  = 1'b0;
    hvin        = '0;
    hvout_ready = 1'b0;
    last_out    = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", D'(hvin_ready), D'(1'b1));
    check("reset_valid", D'(hvout_valid), D'(1'b0));
    check("reset_hvout", hvout, '0);
    rst = 1'b0;
    @(negedge clk);

    // Warm-up and basic bind
    send(onehot(0), 1'b0, 0, 1'b0, 1'b0);
    send(onehot(5), 1'b0, 0, 1'b0, 1'b0);
    send(onehot(10), 1'b0, 0, 1'b0, 1'b0);
    check("basic_bind", last_out, onehot(10) | onehot(6) | onehot(2));

    // Sliding window plus 10 cycles of backpressure
    send(onehot(20), 1'b0, 10, 1'b0, 1'b0);
    check("sliding", last_out, onehot(20) | onehot(11) | onehot(7));

    // Wrap-around across bit D-1
    send(onehot(1999), 1'b1, 0, 1'b0, 1'b0);
    send(onehot(1999), 1'b0, 0, 1'b0, 1'b0);
    send('0, 1'b0, 0, 1'b0, 1'b0);
    check("wrap", last_out, onehot(0) | onehot(1));

    // seq_clear together with a fire; later seq_clear pulsed during COMPUTE
    send(onehot(3), 1'b1, 0, 1'b0, 1'b0);
    send(onehot(4), 1'b0, 0, 1'b0, 1'b0);
    send(onehot(5), 1'b0, 0, 1'b1, 1'b0);
    check("seq_clear_bind", last_out, onehot(5));
    send(rand_hv(), 1'b0, 0, 1'b0, 1'b0);

    // Reset on the 3rd COMPUTE cycle, then a fresh warm-up
    send(rand_hv(), 1'b0, 0, 1'b0, 1'b1);
    send(rand_hv(), 1'b0, 0, 1'b0, 1'b0);
    send(rand_hv(), 1'b0, 0, 1'b0, 1'b0);
    send(rand_hv(), 1'b0, 2, 1'b0, 1'b0);

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      send(rand_hv(), ($urandom_range(7) == 0), int'($urandom_range(3)),
           ($urandom_range(3) == 0), 1'b0);
    end

    repeat (2) @(negedge clk);
    check("output_count", D'(obs_outs), D'(exp_outs));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
